// File: rtl/prog_loader_if.sv
// Program-RAM load port between the serial loader and the CPU.
// The loader drives the write strobe, address, data and CPU reset.
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();
  logic              prog;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              cpu_reset;

  modport master (output prog, output prog_addr, output prog_data, output cpu_reset);
  modport slave  (input  prog, input  prog_addr, input  prog_data, input  cpu_reset);
endinterface

// File: rtl/prog_loader.sv
// Serial (SPI mode 0, MSB first) program loader writing bytes into sequential CPU RAM
// addresses while holding the CPU in reset.
//
// state | meaning
// IDLE  | no session; waiting for a cs_n falling edge
// SHIFT | collecting bits of the current byte on sclk rising edges
// WRITE | one-cycle prog strobe for the assembled byte
// FULL  | RAM full; further bits only raise overrun
module prog_loader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              sdi,
  prog_loader_if.master     ram,
  output logic              busy,
  output logic [ADDR_W:0]   byte_count,
  output logic              overrun
);

  localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(2**ADDR_W);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, FULL} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] cs_sr, sclk_sr, sdi_sr;
  logic                   cs_prev, sclk_prev;
  logic                   cs_s, sclk_s, sdi_s;
  logic                   cs_fall, sclk_rise;

  logic [BC_W-1:0]   bit_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DATA_W-1:0] shift_reg, shift_nx;
  logic              loaded;

  // Synchronizers reset to idle pin levels so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sr     <= '1;
      sclk_sr   <= '0;
      sdi_sr    <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      sdi_sr    <= {sdi_sr[SYNC_STAGES-2:0], sdi};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign sdi_s     = sdi_sr[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign shift_nx  = {shift_reg[DATA_W-2:0], sdi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // cs_n high is tested as a level so a rise seen during WRITE is acted on one cycle later.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (cs_fall) state_nx = SHIFT;
      SHIFT: begin
        if (cs_s)                                  state_nx = IDLE;
        else if (sclk_rise && bit_cnt == BIT_LAST) state_nx = WRITE;
      end
      WRITE: state_nx = (addr_cnt == ADDR_MAX) ? FULL : SHIFT;
      FULL:  if (cs_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt       <= '0;
      addr_cnt      <= '0;
      shift_reg     <= '0;
      byte_count    <= '0;
      overrun       <= 1'b0;
      loaded        <= 1'b0;
      busy          <= 1'b0;
      ram.prog      <= 1'b0;
      ram.prog_addr <= '0;
      ram.prog_data <= '0;
      ram.cpu_reset <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt    <= '0;
            addr_cnt   <= '0;
            byte_count <= '0;
            overrun    <= 1'b0;
          end
        end
        SHIFT: begin
          if (!cs_s && sclk_rise) begin
            shift_reg <= shift_nx;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              ram.prog_addr <= addr_cnt;
              ram.prog_data <= shift_nx;
            end
          end
        end
        WRITE: begin
          bit_cnt <= '0;
          if (byte_count != DEPTH) byte_count <= byte_count + 1'b1;
          if (addr_cnt != ADDR_MAX) addr_cnt <= addr_cnt + 1'b1;
        end
        FULL: begin
          if (!cs_s && sclk_rise) overrun <= 1'b1;
        end
        default: ;
      endcase

      if (state != IDLE && state_nx == IDLE) loaded <= 1'b1;
      busy          <= (state_nx != IDLE);
      ram.prog      <= (state_nx == WRITE);
      ram.cpu_reset <= (state != IDLE) || (state_nx != IDLE) || !loaded;
    end
  end

endmodule
